mem_access_stage: RTL and testbench

//  MEM stage of the 5-stage pipeline: EX/MEM slot register plus data-memory access FSM.
//  - Captures EX results into a slot and performs a load/store over a ready-handshake memory port.
//  - Presents ALU/memory results, WN, MReg and EnRW to the MEM/WB register, which selects the result.
//  - MEM/WB has no enable, so this stage stalls upstream and emits bubbles (EnRW_out=0) while waiting.

---
 rtl/mem_access_stage.sv | 167 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: EX/MEM slot register plus the data-memory access FSM.
// While a load/store waits on the memory, the stage holds EX and earlier stages
// and feeds bubbles into MEM/WB (which has no enable of its own).
//
// Handshake: mem_req/mem_we/mem_addr/mem_wdata are held stable from the first
// ACCESS cycle until the cycle in which mem_ready=1 is sampled; that cycle
// completes the transfer (mem_rdata is valid only then). The request may be
// withdrawn without completion only by reset or by the timeout abort.
module mem_access_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int REG_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] ALU_in,
  input  logic [DATA_W-1:0] SData_in,
  input  logic [REG_W-1:0]  WN_in,
  input  logic              MReg_in,
  input  logic              MemWr_in,
  input  logic              EnRW_in,
  input  logic              flush,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] ALU_out,
  output logic [DATA_W-1:0] MEM_out,
  output logic [REG_W-1:0]  WN_out,
  output logic              MReg_out,
  output logic              EnRW_out,
  output logic              mem_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   alu_q, alu_d;
  logic [DATA_W-1:0]   sdata_q, sdata_d;
  logic [REG_W-1:0]    wn_q, wn_d;
  logic                mreg_q, mreg_d;
  logic                memwr_q, memwr_d;
  logic                enrw_q, enrw_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                abort_q, abort_d;
  logic                cap_valid;
  logic                cap_memop;

  // State and slot registers; reset empties the slot and drops any request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      valid_q <= 1'b0;
      alu_q   <= '0;
      sdata_q <= '0;
      wn_q    <= '0;
      mreg_q  <= 1'b0;
      memwr_q <= 1'b0;
      enrw_q  <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      alu_q   <= alu_d;
      sdata_q <= sdata_d;
      wn_q    <= wn_d;
      mreg_q  <= mreg_d;
      memwr_q <= memwr_d;
      enrw_q  <= enrw_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  // Next-state logic, slot capture and all stage outputs.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    alu_d     = alu_q;
    sdata_d   = sdata_q;
    wn_d      = wn_q;
    mreg_d    = mreg_q;
    memwr_d   = memwr_q;
    enrw_d    = enrw_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    abort_d   = abort_q;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    MReg_out  = 1'b0;
    EnRW_out  = 1'b0;
    cap_valid = in_valid & ~flush;
    cap_memop = cap_valid & (MReg_in | MemWr_in);

    case (state_q)
      ST_ACCESS: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = memwr_q;
        mem_addr  = alu_q[ADDR_W-1:0];
        mem_wdata = sdata_q;
        cnt_d     = cnt_q + 1'b1;
        // A completion in the timeout cycle still counts as success.
        if (mem_ready) begin
          if (mreg_q) rdata_d = mem_rdata;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          abort_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      default: begin
        if (state_q == ST_DONE) begin
          MReg_out = mreg_q & ~abort_q;
          EnRW_out = valid_q & enrw_q & ~(abort_q & mreg_q);
        end else begin
          EnRW_out = valid_q & enrw_q;
        end
        // Not stalled: take the EX instruction (or a bubble on flush).
        valid_d = cap_valid;
        alu_d   = ALU_in;
        sdata_d = SData_in;
        wn_d    = WN_in;
        // Load+store together behaves as a plain store.
        mreg_d  = MReg_in & ~MemWr_in;
        memwr_d = MemWr_in;
        enrw_d  = EnRW_in;
        abort_d = 1'b0;
        cnt_d   = '0;
        state_d = cap_memop ? ST_ACCESS : ST_RUN;
      end
    endcase
  end

  assign ALU_out = alu_q;
  assign WN_out  = wn_q;
  assign MEM_out = rdata_q;
  assign mem_err = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a vector table for single-cycle ops,
// then hand-written sequences for loads, stores, timeout, back-to-back and reset.
module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] ALU_in;
  logic [31:0] SData_in;
  logic [3:0]  WN_in;
  logic        MReg_in;
  logic        MemWr_in;
  logic        EnRW_in;
  logic        flush;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] ALU_out;
  logic [31:0] MEM_out;
  logic [3:0]  WN_out;
  logic        MReg_out;
  logic        EnRW_out;
  logic        mem_err;

  int n_total = 0;
  int n_pass  = 0;

  mem_access_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ALU_in(ALU_in),
    .SData_in(SData_in), .WN_in(WN_in), .MReg_in(MReg_in), .MemWr_in(MemWr_in),
    .EnRW_in(EnRW_in), .flush(flush), .stall(stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .ALU_out(ALU_out),
    .MEM_out(MEM_out), .WN_out(WN_out), .MReg_out(MReg_out),
    .EnRW_out(EnRW_out), .mem_err(mem_err)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        v;
    logic [31:0] alu;
    logic [3:0]  wn;
    logic        enrw;
    logic        fl;
    logic [31:0] exp_alu;
    logic [3:0]  exp_wn;
    logic        exp_enrw;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: act=0x%08h exp=0x%08h", name, act, exp);
  endtask

  task automatic idle_inputs();
    in_valid = 0; ALU_in = 0; SData_in = 0; WN_in = 0;
    MReg_in = 0; MemWr_in = 0; EnRW_in = 0; flush = 0;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [3:0] wn, input logic mr, input logic mw,
                       input logic en, input logic fl);
    in_valid = v; ALU_in = alu; SData_in = sd; WN_in = wn;
    MReg_in = mr; MemWr_in = mw; EnRW_in = en; flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hi_cnt;
    reset = 1; mem_rdata = 0; mem_ready = 0;
    idle_inputs();

    vecs[0] = '{1, 32'h0000_1234, 4'd3,  1, 0, 32'h0000_1234, 4'd3,  1};
    vecs[1] = '{1, 32'hFFFF_FFFF, 4'd15, 1, 0, 32'hFFFF_FFFF, 4'd15, 1};
    vecs[2] = '{1, 32'h0000_CAFE, 4'd1,  0, 0, 32'h0000_CAFE, 4'd1,  0};
    vecs[3] = '{0, 32'h0000_0077, 4'd2,  1, 0, 32'h0000_0077, 4'd2,  0};
    vecs[4] = '{1, 32'h0000_0099, 4'd4,  1, 1, 32'h0000_0099, 4'd4,  0};
    vecs[5] = '{1, 32'h0000_0000, 4'd0,  1, 0, 32'h0000_0000, 4'd0,  1};

    // Reset state while reset is held.
    #12;
    check("rst_stall",   stall,    0);
    check("rst_mem_req", mem_req,  0);
    check("rst_alu",     ALU_out,  0);
    check("rst_mem_out", MEM_out,  0);
    check("rst_enrw",    EnRW_out, 0);
    check("rst_err",     mem_err,  0);
    reset = 0;

    // Single-cycle ops from the table.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].v, vecs[i].alu, 0, vecs[i].wn, 0, 0, vecs[i].enrw, vecs[i].fl);
      step();
      check($sformatf("vec%0d_alu", i),     ALU_out,  vecs[i].exp_alu);
      check($sformatf("vec%0d_wn", i),      WN_out,   vecs[i].exp_wn);
      check($sformatf("vec%0d_enrw", i),    EnRW_out, vecs[i].exp_enrw);
      check($sformatf("vec%0d_stall", i),   stall,    0);
      check($sformatf("vec%0d_mem_req", i), mem_req,  0);
      check($sformatf("vec%0d_mreg", i),    MReg_out, 0);
    end

    // Load, ready on the first request cycle.
    drive(1, 32'h0000_0010, 0, 4'd5, 1, 0, 1, 0);
    step();
    check("ld_stall",   stall,    1);
    check("ld_req",     mem_req,  1);
    check("ld_we",      mem_we,   0);
    check("ld_addr",    mem_addr, 16'h0010);
    check("ld_enrw",    EnRW_out, 0);
    idle_inputs();
    mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ready = 0; mem_rdata = 0;
    check("ld_done_stall", stall,    0);
    check("ld_done_req",   mem_req,  0);
    check("ld_done_data",  MEM_out,  32'hDEAD_BEEF);
    check("ld_done_mreg",  MReg_out, 1);
    check("ld_done_enrw",  EnRW_out, 1);
    check("ld_done_wn",    WN_out,   5);

    // Store, ready after 3 waiting cycles (4 request cycles).
    drive(1, 32'h0000_0020, 32'hA5A5_A5A5, 4'd6, 0, 1, 0, 0);
    step();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("st_req%0d", i),   mem_req,   1);
      check($sformatf("st_we%0d", i),    mem_we,    1);
      check($sformatf("st_stall%0d", i), stall,     1);
      check($sformatf("st_enrw%0d", i),  EnRW_out,  0);
      check($sformatf("st_addr%0d", i),  mem_addr,  16'h0020);
      check($sformatf("st_wd%0d", i),    mem_wdata, 32'hA5A5_A5A5);
      mem_ready = (i == 3);
      step();
    end
    mem_ready = 0;
    check("st_done_req",   mem_req,  0);
    check("st_done_stall", stall,    0);
    check("st_done_enrw",  EnRW_out, 0);
    check("st_done_mreg",  MReg_out, 0);
    check("st_done_data",  MEM_out,  32'hDEAD_BEEF);

    // Load that never completes: 16 request cycles, then abort.
    drive(1, 32'h0000_0030, 0, 4'd7, 1, 0, 1, 0);
    step();
    idle_inputs();
    hi_cnt = 0;
    for (int i = 0; i < 40 && mem_req; i++) begin
      hi_cnt++;
      step();
    end
    check("to_req_cycles", hi_cnt,   16);
    check("to_err",        mem_err,  1);
    check("to_stall",      stall,    0);
    check("to_enrw",       EnRW_out, 0);
    check("to_mreg",       MReg_out, 0);
    // Following instruction proceeds normally.
    drive(1, 32'h0000_0055, 0, 4'd2, 0, 0, 1, 0);
    step();
    check("to_next_alu",  ALU_out,  32'h0000_0055);
    check("to_next_enrw", EnRW_out, 1);
    check("to_next_err",  mem_err,  1);
    check("to_next_req",  mem_req,  0);

    // Back-to-back loads, both ready at once.
    drive(1, 32'h0000_0030, 0, 4'd8, 1, 0, 1, 0);
    step();
    check("b2b_req0",  mem_req,  1);
    check("b2b_enrw0", EnRW_out, 0);
    drive(1, 32'h0000_0034, 0, 4'd9, 1, 0, 1, 0);
    mem_ready = 1; mem_rdata = 32'h1111_1111;
    step();
    check("b2b_req1",  mem_req,  0);
    check("b2b_enrw1", EnRW_out, 1);
    check("b2b_dat1",  MEM_out,  32'h1111_1111);
    check("b2b_wn1",   WN_out,   8);
    mem_rdata = 32'h2222_2222;
    step();
    check("b2b_req2",  mem_req,  1);
    check("b2b_enrw2", EnRW_out, 0);
    check("b2b_addr2", mem_addr, 16'h0034);
    idle_inputs();
    step();
    mem_ready = 0; mem_rdata = 0;
    check("b2b_enrw3", EnRW_out, 1);
    check("b2b_dat2",  MEM_out,  32'h2222_2222);
    check("b2b_wn2",   WN_out,   9);

    // Load+store together acts as a store.
    drive(1, 32'h0000_0044, 32'h0BAD_F00D, 4'd3, 1, 1, 1, 0);
    step();
    check("ls_we", mem_we, 1);
    idle_inputs();
    mem_ready = 1; mem_rdata = 32'h3333_3333;
    step();
    mem_ready = 0;
    check("ls_mreg", MReg_out, 0);
    check("ls_data", MEM_out,  32'h2222_2222);

    // Reset in the middle of an access.
    drive(1, 32'h0000_0050, 0, 4'd4, 1, 0, 1, 0);
    step();
    check("rm_req_before", mem_req, 1);
    idle_inputs();
    #1 reset = 1;
    #1;
    check("rm_req",   mem_req,  0);
    check("rm_stall", stall,    0);
    check("rm_alu",   ALU_out,  0);
    check("rm_enrw",  EnRW_out, 0);
    check("rm_err",   mem_err,  0);
    #1 reset = 0;
    step();
    check("rm_after_req", mem_req, 0);

    // Flush together with a load captures a bubble.
    drive(1, 32'h0000_0040, 0, 4'd5, 1, 0, 1, 1);
    step();
    check("fl_req",   mem_req,  0);
    check("fl_stall", stall,    0);
    check("fl_enrw",  EnRW_out, 0);
    check("fl_mreg",  MReg_out, 0);
    idle_inputs();
    step();
    check("fl_req2",  mem_req,  0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
